// File: rtl/lsu_mem_stage_pkg.sv
// ============================================================================
//  Module   : lsu_mem_stage_pkg
//  Brief    : Access size codes, LSU FSM state encoding and alignment helper.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package lsu_mem_stage_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;
  localparam logic [1:0] LSU_SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic r;
    case (size)
      LSU_SIZE_H: r = off[0];
      LSU_SIZE_W: r = |off[1:0];
      LSU_SIZE_D: r = |off;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
//  Module   : lsu_align
//  Brief    : Store byte-lane shift / mask and load extract with extension.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [2:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_lane_wdata,
  output logic [7:0]  o_lane_wmask,
  output logic [63:0] o_load_data
);

  logic [5:0]  w_shamt;
  logic [63:0] w_rsh;

  assign w_shamt      = {i_off, 3'b000};
  assign o_lane_wdata = i_wdata << w_shamt;
  assign w_rsh        = i_rdata >> w_shamt;

  always_comb begin
    o_lane_wmask = 8'h00;
    case (i_size)
      LSU_SIZE_B: o_lane_wmask = 8'h01 << i_off;
      LSU_SIZE_H: o_lane_wmask = 8'h03 << i_off;
      LSU_SIZE_W: o_lane_wmask = 8'h0F << i_off;
      default:    o_lane_wmask = 8'hFF;
    endcase
  end

  always_comb begin
    o_load_data = w_rsh;
    case (i_size)
      LSU_SIZE_B: o_load_data = {{56{~i_unsigned & w_rsh[7]}},  w_rsh[7:0]};
      LSU_SIZE_H: o_load_data = {{48{~i_unsigned & w_rsh[15]}}, w_rsh[15:0]};
      LSU_SIZE_W: o_load_data = {{32{~i_unsigned & w_rsh[31]}}, w_rsh[31:0]};
      default:    o_load_data = w_rsh;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_stage.sv
// ============================================================================
//  Module   : lsu_mem_stage
//  Brief    : Registered, handshaked load/store stage on a 64-bit memory bus.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_rdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int                 c_cnt_w   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT_CYC);

  lsu_state_t         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_off;
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic               r_we;

  logic [2:0]  w_off;
  logic [1:0]  w_size;
  logic        w_unsigned;
  logic [63:0] w_lane_wdata;
  logic [7:0]  w_lane_wmask;
  logic [63:0] w_load_data;

  // Live request fields feed the store lanes at accept; captured fields feed load extract.
  assign w_off      = (r_state == ST_IDLE) ? req_addr[2:0] : r_off;
  assign w_size     = (r_state == ST_IDLE) ? req_size      : r_size;
  assign w_unsigned = (r_state == ST_IDLE) ? req_unsigned  : r_unsigned;

  lsu_align u_align (
    .i_off        (w_off),
    .i_size       (w_size),
    .i_unsigned   (w_unsigned),
    .i_wdata      (req_wdata),
    .i_rdata      (mem_rsp_rdata),
    .o_lane_wdata (w_lane_wdata),
    .o_lane_wmask (w_lane_wmask),
    .o_load_data  (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_off         <= 3'd0;
      r_size        <= 2'd0;
      r_unsigned    <= 1'b0;
      r_we          <= 1'b0;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_addr      <= 64'd0;
      mem_we        <= 1'b0;
      mem_wdata     <= 64'd0;
      mem_wmask     <= 8'h00;
      resp_valid    <= 1'b0;
      resp_rdata    <= 64'd0;
      resp_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_off      <= req_addr[2:0];
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_we       <= req_we;
            r_cnt      <= '0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            if (lsu_misaligned(req_size, req_addr[2:0])) begin
              r_state    <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 64'd0;
            end else begin
              r_state       <= ST_REQ;
              mem_req_valid <= 1'b1;
              mem_addr      <= {req_addr[63:3], 3'b000};
              mem_we        <= req_we;
              mem_wdata     <= req_we ? w_lane_wdata : 64'd0;
              mem_wmask     <= req_we ? w_lane_wmask : 8'h00;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            r_cnt         <= '0;
            r_state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            r_state    <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= r_we ? 64'd0 : w_load_data;
          end else if (r_cnt == c_timeout) begin
            r_state    <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 64'd0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_state    <= ST_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 64'd0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
// ============================================================================
//  Module   : tb_lsu_mem_stage
//  Brief    : Directed self-checking bench for lsu_mem_stage.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_mem_stage;
  import lsu_mem_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_stage #(.TIMEOUT_CYC(255)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] wd, input logic we,
                       input logic [1:0] sz, input logic uns);
    req_valid    = 1'b1;
    req_addr     = a;
    req_wdata    = wd;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    tick();
    req_valid    = 1'b0;
  endtask

  task automatic ack();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
  endtask

  task automatic rsp(input logic [63:0] d);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = d;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [63:0] a, input logic [1:0] sz,
                         input logic uns, input logic [63:0] rd, input logic [63:0] exp);
    issue(a, 64'd0, 1'b0, sz, uns);
    ack();
    rsp(rd);
    chk({tag, "_vld_err"}, {62'd0, resp_valid, resp_err}, 64'd2);
    chk({tag, "_rdata"}, resp_rdata, exp);
    tick();
  endtask

  initial begin
    int  n;
    logic seen;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0;
    req_size = 2'd0; req_unsigned = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    repeat (2) tick();
    chk("reset_state", {60'd0, req_ready, busy, mem_req_valid, resp_valid}, 64'h8);
    chk("reset_outs", {mem_we, mem_wmask, resp_err}, 10'd0);
    rst_n = 1'b1;
    tick();

    // LW signed: address/mask on bus, then 3-cycle latency to resp_valid.
    issue(64'h8000_0004, 64'd0, 1'b0, LSU_SIZE_W, 1'b0);
    chk("lw_req", {61'd0, mem_req_valid, req_ready, busy}, 64'h5);
    chk("lw_addr", mem_addr, 64'h8000_0000);
    chk("lw_wmask", {56'd0, mem_wmask}, 64'd0);
    ack();
    chk("lw_wait_novalid", {63'd0, resp_valid}, 64'd0);
    rsp(64'h8765_4321_0000_0000);
    chk("lw_vld_err", {62'd0, resp_valid, resp_err}, 64'd2);
    chk("lw_rdata", resp_rdata, 64'hFFFF_FFFF_8765_4321);
    tick();
    chk("lw_done", {61'd0, resp_valid, req_ready, busy}, 64'h2);

    do_load("lwu", 64'h8000_0004, LSU_SIZE_W, 1'b1, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
    do_load("lb",  64'h8000_0005, LSU_SIZE_B, 1'b0, 64'h0000_F000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF0);
    do_load("lbu", 64'h8000_0005, LSU_SIZE_B, 1'b1, 64'h0000_F000_0000_0000, 64'h0000_0000_0000_00F0);
    do_load("lh",  64'h8000_0006, LSU_SIZE_H, 1'b0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    do_load("lhu", 64'h8000_0006, LSU_SIZE_H, 1'b1, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001);
    do_load("ldu", 64'h8000_0000, LSU_SIZE_D, 1'b1, 64'hF123_4567_89AB_CDEF, 64'hF123_4567_89AB_CDEF);

    // SB with bus stalled for 5 cycles: request fields must hold.
    issue(64'h8000_0003, 64'h0000_0000_0000_00AB, 1'b1, LSU_SIZE_B, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("sb_hold_ctl", {60'd0, mem_req_valid, mem_we, req_ready, busy}, 64'hD);
      chk("sb_hold_mask", {56'd0, mem_wmask}, 64'h08);
      chk("sb_hold_wdata", mem_wdata, 64'h0000_0000_AB00_0000);
      chk("sb_hold_addr", mem_addr, 64'h8000_0000);
      tick();
    end
    ack();
    rsp(64'hDEAD_BEEF_DEAD_BEEF);
    chk("sb_vld_err", {62'd0, resp_valid, resp_err}, 64'd2);
    chk("sb_rdata", resp_rdata, 64'd0);
    tick();

    // Misaligned LH: error response the cycle after accept, no bus request.
    issue(64'h8000_0001, 64'd0, 1'b0, LSU_SIZE_H, 1'b0);
    chk("lh_mis", {61'd0, resp_valid, resp_err, mem_req_valid}, 64'h6);
    chk("lh_mis_rdata", resp_rdata, 64'd0);
    tick();
    chk("lh_mis_done", {62'd0, resp_valid, req_ready}, 64'h1);

    // Response coincident with request acceptance is ignored.
    issue(64'h8000_0000, 64'd0, 1'b0, LSU_SIZE_W, 1'b0);
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = '1;
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    chk("same_cyc_ignored", {63'd0, resp_valid}, 64'd0);
    rsp(64'h0000_0000_1234_5678);
    chk("same_cyc_rdata", resp_rdata, 64'h0000_0000_1234_5678);
    tick();

    // Timeout: no response ever arrives.
    issue(64'h8000_0000, 64'd0, 1'b0, LSU_SIZE_D, 1'b0);
    ack();
    n = 0;
    while (!resp_valid && n < 400) begin
      tick();
      n++;
    end
    chk("to_cycles", 64'(n), 64'd256);
    chk("to_vld_err", {62'd0, resp_valid, resp_err}, 64'd3);
    chk("to_rdata", resp_rdata, 64'd0);
    tick();

    // Reset mid-WAIT aborts without a response.
    issue(64'h8000_0000, 64'd0, 1'b0, LSU_SIZE_D, 1'b0);
    ack();
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_abort", {60'd0, req_ready, busy, resp_valid, mem_req_valid}, 64'h8);
    tick();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      mem_rsp_valid = 1'b0;
      if (resp_valid) seen = 1'b1;
    end
    chk("rst_no_resp", {63'd0, seen}, 64'd0);

    // Back-to-back LD then SD.
    issue(64'h8000_0008, 64'd0, 1'b0, LSU_SIZE_D, 1'b0);
    ack();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h1122_3344_5566_7788;
    req_valid = 1'b1; req_addr = 64'h8000_0010; req_wdata = 64'h0102_0304_0506_0708;
    req_we = 1'b1; req_size = LSU_SIZE_D; req_unsigned = 1'b0;
    tick();
    mem_rsp_valid = 1'b0;
    chk("b2b_ld_resp", {62'd0, resp_valid, req_ready}, 64'h2);
    chk("b2b_ld_rdata", resp_rdata, 64'h1122_3344_5566_7788);
    tick();
    chk("b2b_idle", {62'd0, req_ready, resp_valid}, 64'h2);
    tick();
    req_valid = 1'b0;
    chk("b2b_sd_req", {62'd0, mem_req_valid, mem_we}, 64'h3);
    chk("b2b_sd_mask", {56'd0, mem_wmask}, 64'hFF);
    chk("b2b_sd_addr", mem_addr, 64'h8000_0010);
    chk("b2b_sd_wdata", mem_wdata, 64'h0102_0304_0506_0708);
    ack();
    rsp(64'd0);
    chk("b2b_sd_resp", {62'd0, resp_valid, resp_err}, 64'd2);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
